// File: rtl/ram_param_pkg.sv
// Shared definitions for the parametrised RAM: FSM state encodings and
// default geometry used by ram_param and ram_clear_seq.
package ram_param_pkg;

   typedef enum logic {
      RAM_ST_IDLE  = 1'b0,
      RAM_ST_CLEAR = 1'b1
   } ram_state_t;

   localparam int RAM_DEF_WIDTH = 16;
   localparam int RAM_DEF_DEPTH = 512;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks ptr over 0..DEPTH-1 writing zeros, drives busy.
// Ports: clock, reset_n, clear in; busy, clr_we, clr_addr out.
module ram_clear_seq
   import ram_param_pkg::*;
#(
   parameter int DEPTH  = RAM_DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   ram_state_t        state;
   logic [ADDR_W-1:0] ptr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RAM_ST_CLEAR;
         ptr   <= '0;
         busy  <= 1'b1;
      end else begin
         unique case (state)
            RAM_ST_CLEAR: begin
               if (ptr == LAST) begin
                  state <= RAM_ST_IDLE;
                  busy  <= 1'b0;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            RAM_ST_IDLE: begin
               if (clear) begin
                  state <= RAM_ST_CLEAR;
                  busy  <= 1'b1;
                  ptr   <= '0;
               end
            end
         endcase
      end
   end

   // Gated by reset_n so edges seen while reset is held leave the array alone.
   assign clr_we   = (state == RAM_ST_CLEAR) & reset_n;
   assign clr_addr = ptr;

endmodule

// File: rtl/ram_param.sv
// Parametrised RAM with combinational read, clocked write, hardware clear.
// Ports: clock, reset_n, in, address, load, clear in; out, busy out.
// Optional macro RAM_PARAM_BYPASS_EN: write-first forwarding of in to out.
module ram_param
   import ram_param_pkg::*;
#(
   parameter  int WIDTH  = RAM_DEF_WIDTH,
   parameter  int DEPTH  = RAM_DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  in,
   input  logic [ADDR_W-1:0] address,
   input  logic              load,
   input  logic              clear,
   output logic [WIDTH-1:0]  out,
   output logic              busy
);

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              in_range;
   logic              user_we;
   logic [WIDTH-1:0]  mem [DEPTH];

   ram_clear_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_seq (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (clear),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // Only reachable as false when DEPTH is not a power of two.
   assign in_range = 32'(address) < 32'(DEPTH);

   // A clear request on the same edge wins over a user write.
   assign user_we = load & in_range & ~busy & ~clear;

   always_ff @(posedge clock) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (user_we) begin
         mem[address] <= in;
      end
   end

   always_comb begin
      out = '0;
      if (!busy && in_range) begin
`ifdef RAM_PARAM_BYPASS_EN
         if (load) begin
            out = in;
         end else begin
            out = mem[address];
         end
`else
         out = mem[address];
`endif
      end
   end

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param at DEPTH=512 and DEPTH=300, with a
// behavioural model compared every cycle plus literal directed checks.
module tb_ram_param;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        load = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] din = '0;
   logic [8:0]  addr = '0;
   logic [15:0] out_a, out_b;
   logic        busy_a, busy_b;

   int checks = 0;
   int failures = 0;

   ram_param #(.WIDTH(16), .DEPTH(512)) dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .in      (din),
      .address (addr),
      .load    (load),
      .clear   (clear),
      .out     (out_a),
      .busy    (busy_a)
   );

   ram_param #(.WIDTH(16), .DEPTH(300)) dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .in      (din),
      .address (addr),
      .load    (load),
      .clear   (clear),
      .out     (out_b),
      .busy    (busy_b)
   );

   initial forever #5 clock = ~clock;

   // Model: rem = clear edges still owed; contents zeroed when it hits 0.
   int          rem [2] = '{512, 300};
   logic [15:0] m [2][512];

   function automatic int dep(input int k);
      return (k == 0) ? 512 : 300;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset_n) begin
            rem[k] <= dep(k);
         end else if (rem[k] > 0) begin
            rem[k] <= rem[k] - 1;
            if (rem[k] == 1)
               for (int j = 0; j < 512; j++) m[k][j] <= '0;
         end else if (clear) begin
            rem[k] <= dep(k);
         end else if (load && int'(addr) < dep(k)) begin
            m[k][addr] <= din;
         end
      end
   end

   function automatic logic [15:0] exp_out(input int k);
      if (rem[k] > 0) return '0;
      if (int'(addr) >= dep(k)) return '0;
`ifdef RAM_PARAM_BYPASS_EN
      if (load) return din;
`endif
      return m[k][addr];
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      check("model_out_a", 32'(out_a), 32'(exp_out(0)));
      check("model_out_b", 32'(out_b), 32'(exp_out(1)));
      check("model_busy_a", 32'(busy_a), 32'(rem[0] > 0));
      check("model_busy_b", 32'(busy_b), 32'(rem[1] > 0));
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [8:0] a, input logic [15:0] ea,
                     input string nm);
      addr = a;
      #2;
      check(nm, 32'(out_a), 32'(ea));
      step();
   endtask

   // Edges until each instance drops busy; 0 means the bound expired.
   task automatic wait_idle(output int na, output int nb);
      na = 0;
      nb = 0;
      for (int e = 1; e <= 2000; e++) begin
         @(posedge clock);
         #1;
         if (!busy_a && na == 0) na = e;
         if (!busy_b && nb == 0) nb = e;
         if (na != 0 && nb != 0) break;
      end
   endtask

   int na, nb;

   initial begin
      #1;
      reset_n = 1'b0;
      #1;
      check("reset_busy", 32'(busy_a), 32'd1);
      check("reset_out", 32'(out_a), 32'd0);
      repeat (3) step();
      reset_n = 1'b1;
      wait_idle(na, nb);
      check("clr_edges_512", 32'(na), 32'd512);
      check("clr_edges_300", 32'(nb), 32'd300);
      for (int a = 0; a < 512; a++) rd(9'(a), 16'h0, "zero_sweep");

      load = 1'b1; addr = 9'd128; din = 16'd15;
      step();
      load = 1'b0;
      for (int a = 0; a < 512; a += 16)
         rd(9'(a), (a == 128) ? 16'd15 : 16'd0, "wr_sweep");

      load = 1'b1; addr = 9'd5; din = 16'hBEEF;
      step();
      load = 1'b0;
      rd(9'd5, 16'hBEEF, "beef_wr");
      clear = 1'b1; load = 1'b1; din = 16'h1234; addr = 9'd7;
      step();
      clear = 1'b0; load = 1'b0;
      check("clear_busy", 32'(busy_a), 32'd1);
      wait_idle(na, nb);
      check("clr_req_512", 32'(na), 32'd512);
      check("clr_req_300", 32'(nb), 32'd300);
      rd(9'd5, 16'h0, "beef_cleared");
      rd(9'd7, 16'h0, "write_dropped");

      clear = 1'b1;
      step();
      clear = 1'b0;
      repeat (200) step();
      reset_n = 1'b0;
      step();
      step();
      check("midrst_busy", 32'(busy_a), 32'd1);
      reset_n = 1'b1;
      wait_idle(na, nb);
      check("midrst_512", 32'(na), 32'd512);
      check("midrst_300", 32'(nb), 32'd300);

      load = 1'b1; addr = 9'd310; din = 16'd9;
      step();
      load = 1'b0;
      #2;
      check("oor_out_b", 32'(out_b), 32'd0);
      check("inr_out_a", 32'(out_a), 32'd9);
      step();

      addr = 9'd3; din = 16'd77; load = 1'b1;
      #2;
`ifdef RAM_PARAM_BYPASS_EN
      check("bypass_pre", 32'(out_a), 32'd77);
`else
      check("bypass_pre", 32'(out_a), 32'd0);
`endif
      step();
      load = 1'b0;
      #2;
      check("bypass_post", 32'(out_a), 32'd77);
      step();

      for (int i = 0; i < 3000; i++) begin
         addr = 9'($urandom_range(511, 0));
         din = 16'($urandom);
         load = ($urandom_range(2, 0) != 0);
         clear = ($urandom_range(299, 0) == 0);
         if ($urandom_range(999, 0) == 0) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
         end
         step();
      end
      load = 1'b0;
      clear = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
